// File: rtl/latch_value_reader.sv
`default_nettype none
// ============================================================================
// Module   : latch_value_reader
// Purpose  : Clocked reader for an enable-latched incrementer bank. Tracks the
//            latch enable, waits for the latch to close and settle, samples
//            the latched (operand + 1) code, decodes it back to the operand,
//            flags illegal codes and hands the result downstream on a
//            valid/ready handshake.
//
// Ports    : clk        - rising-edge clock for all state
//            rst        - synchronous active-high reset, highest priority
//            en         - latch enable seen by the upstream latches
//            lat_q      - latch outputs (W+1 bits, operand + 1)
//            out_ready  - downstream ready
//            out_valid  - decoded result available
//            out_data   - decoded operand (lat_q - 1, W bits)
//            out_err    - sampled code was outside 1..2^W
//            out_ovr    - sticky: a new window opened while a result waited
//            cap_cnt    - saturating count of completed transfers
//
// Revision : 1.0 - initial release
// ============================================================================
module latch_value_reader #(
    parameter int W          = 2,   // operand width; latched code is W+1 bits
    parameter int SETTLE_CYC = 1,   // settle cycles after en low, 1..15
    parameter int CNT_W      = 8    // transfer counter width
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [W:0]       lat_q,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic             out_err,
    output logic             out_ovr,
    output logic [CNT_W-1:0] cap_cnt
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // The settle counter is loaded when en is first seen low and the capture
    // happens on the edge where it reads zero, so loading SETTLE_CYC-1 makes
    // out_valid rise exactly SETTLE_CYC edges after that first low sample.
    localparam logic [3:0]       c_SETTLE_LOAD = 4'(SETTLE_CYC - 1);
    // Largest legal code: operand all ones plus one.
    localparam logic [W+1:0]     c_MAX_CODE    = (W+2)'(2 ** W);
    localparam logic [CNT_W-1:0] c_CNT_MAX     = '1;

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,   // latch closed, nothing pending
        ST_OPEN    = 2'd1,   // latch transparent, waiting for en to drop
        ST_SETTLE  = 2'd2,   // latch closed, letting Q settle
        ST_PRESENT = 2'd3    // result held until downstream takes it
    } state_t;

    state_t           state_q,   state_d;
    logic             en_d_q;
    logic [3:0]       settle_q,  settle_d;
    logic             valid_q,   valid_d;
    logic [W-1:0]     data_q,    data_d;
    logic             err_q,     err_d;
    logic             ovr_q,     ovr_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;

    // ------------------------------------------------------------------------
    // Edge detect and handshake qualifiers
    // ------------------------------------------------------------------------
    logic en_rise;
    logic xfer;

    assign en_rise = en & ~en_d_q;
    assign xfer    = valid_q & out_ready;

    // ------------------------------------------------------------------------
    // Decode of the latched code
    // ------------------------------------------------------------------------
    // Legal codes are 1..2^W. Zero can never be produced by in+1 with a W-bit
    // operand, and anything above 2^W means the carry bit and low bits
    // disagree, so both indicate a corrupted or not-yet-settled latch.
    logic         dec_err;
    logic [W-1:0] dec_data;

    assign dec_err  = (lat_q == '0) || ({1'b0, lat_q} > c_MAX_CODE);
    // (q - 1) mod 2^W only depends on the low W bits of q; for the legal
    // code 2^W this wraps to all ones as intended.
    assign dec_data = dec_err ? '0 : (lat_q[W-1:0] - W'(1));

    // ------------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        valid_d  = valid_q;
        data_d   = data_q;
        err_d    = err_q;
        ovr_d    = ovr_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_OPEN;
                end
            end

            ST_OPEN: begin
                if (!en) begin
                    state_d  = ST_SETTLE;
                    settle_d = c_SETTLE_LOAD;
                end
            end

            ST_SETTLE: begin
                if (en) begin
                    // Latch reopened before it settled: drop this window
                    // silently and follow the new one.
                    state_d = ST_OPEN;
                end else if (settle_q == 4'd0) begin
                    state_d = ST_PRESENT;
                    valid_d = 1'b1;
                    data_d  = dec_data;
                    err_d   = dec_err;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end

            ST_PRESENT: begin
                if (xfer) begin
                    valid_d = 1'b0;
                    if (cnt_q != c_CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    // If the enable is already high the new window is simply
                    // tracked from here; data/err keep their last values.
                    state_d = en ? ST_OPEN : ST_IDLE;
                end else if (en_rise) begin
                    // A new window started while the old result is still
                    // waiting; keep the old result and remember the loss.
                    ovr_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            en_d_q   <= 1'b0;
            settle_q <= 4'd0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            err_q    <= 1'b0;
            ovr_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            en_d_q   <= en;
            settle_q <= settle_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            err_q    <= err_d;
            ovr_q    <= ovr_d;
            cnt_q    <= cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs come straight from registers
    // ------------------------------------------------------------------------
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_err   = err_q;
    assign out_ovr   = ovr_q;
    assign cap_cnt   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_latch_value_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_latch_value_reader
// Purpose  : Directed self-checking bench. Instance A uses W=2, SETTLE_CYC=1,
//            CNT_W=8; instance B uses W=2, SETTLE_CYC=3, CNT_W=2.
//            Inputs change 1 time unit after the rising edge and outputs are
//            checked at that same point, i.e. they show the post-edge state.
// Revision : 1.0 - initial release
// ============================================================================
module tb_latch_value_reader;

    logic       clk = 1'b0;

    logic       rst_a, en_a, rdy_a;
    logic [2:0] lat_a;
    logic       valid_a, err_a, ovr_a;
    logic [1:0] data_a;
    logic [7:0] cap_a;

    logic       rst_b, en_b, rdy_b;
    logic [2:0] lat_b;
    logic       valid_b, err_b, ovr_b;
    logic [1:0] data_b;
    logic [1:0] cap_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    latch_value_reader #(.W(2), .SETTLE_CYC(1), .CNT_W(8)) u_dut_a (
        .clk       (clk),
        .rst       (rst_a),
        .en        (en_a),
        .lat_q     (lat_a),
        .out_ready (rdy_a),
        .out_valid (valid_a),
        .out_data  (data_a),
        .out_err   (err_a),
        .out_ovr   (ovr_a),
        .cap_cnt   (cap_a)
    );

    latch_value_reader #(.W(2), .SETTLE_CYC(3), .CNT_W(2)) u_dut_b (
        .clk       (clk),
        .rst       (rst_b),
        .en        (en_b),
        .lat_q     (lat_b),
        .out_ready (rdy_b),
        .out_valid (valid_b),
        .out_data  (data_b),
        .out_err   (err_b),
        .out_ovr   (ovr_b),
        .cap_cnt   (cap_b)
    );

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int s, input logic e, input logic [2:0] l, input logic r);
        if (s == 0) begin
            en_a = e; lat_a = l; rdy_a = r;
        end else begin
            en_b = e; lat_b = l; rdy_b = r;
        end
    endtask

    task automatic set_en(input int s, input logic e);
        if (s == 0) en_a = e;
        else        en_b = e;
    endtask

    function automatic logic [31:0] o_valid(input int s);
        return (s == 0) ? 32'(valid_a) : 32'(valid_b);
    endfunction
    function automatic logic [31:0] o_data(input int s);
        return (s == 0) ? 32'(data_a) : 32'(data_b);
    endfunction
    function automatic logic [31:0] o_err(input int s);
        return (s == 0) ? 32'(err_a) : 32'(err_b);
    endfunction
    function automatic logic [31:0] o_ovr(input int s);
        return (s == 0) ? 32'(ovr_a) : 32'(ovr_b);
    endfunction
    function automatic logic [31:0] o_cnt(input int s);
        return (s == 0) ? 32'(cap_a) : 32'(cap_b);
    endfunction

    task automatic check_all_zero(input int s, input string tag);
        check({tag, "_valid"}, o_valid(s), 0);
        check({tag, "_data"},  o_data(s),  0);
        check({tag, "_err"},   o_err(s),   0);
        check({tag, "_ovr"},   o_ovr(s),   0);
        check({tag, "_cnt"},   o_cnt(s),   0);
    endtask

    task automatic reset_dut(input int s);
        drive(s, 1'b0, 3'd0, 1'b0);
        if (s == 0) rst_a = 1'b1; else rst_b = 1'b1;
        cyc();
        cyc();
        if (s == 0) rst_a = 1'b0; else rst_b = 1'b0;
        check_all_zero(s, "reset");
    endtask

    // One capture window with out_ready held high: en high for nopen edges,
    // then low; out_valid must stay low for settle edges after E0 and be high
    // after edge E0+settle, then transfer on the following edge.
    task automatic window(input int s, input int nopen, input int settle,
                          input logic [2:0] lat, input logic [1:0] exp_d,
                          input logic exp_e, input logic [7:0] exp_cnt);
        drive(s, 1'b1, lat, 1'b1);
        repeat (nopen) cyc();
        set_en(s, 1'b0);
        cyc();                                  // E0
        for (int k = 0; k < settle; k++) begin
            check("win_settle_valid", o_valid(s), 0);
            if (k < settle - 1) cyc();
        end
        cyc();                                  // E0 + settle
        check("win_valid", o_valid(s), 1);
        check("win_data",  o_data(s),  32'(exp_d));
        check("win_err",   o_err(s),   32'(exp_e));
        cyc();                                  // transfer
        check("win_xfer_valid", o_valid(s), 0);
        check("win_cnt",        o_cnt(s),   32'(exp_cnt));
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        rst_a = 1'b1; en_a = 1'b0; rdy_a = 1'b0; lat_a = 3'd0;
        rst_b = 1'b1; en_b = 1'b0; rdy_b = 1'b0; lat_b = 3'd0;

        // ---------------- Instance A: SETTLE_CYC=1, CNT_W=8 ----------------
        reset_dut(0);

        // Basic window: code 3 -> operand 2, one-cycle valid pulse.
        window(0, 3, 1, 3'd3, 2'd2, 1'b0, 8'd1);

        // Code sweep over legal and illegal values.
        reset_dut(0);
        window(0, 2, 1, 3'd1, 2'd0, 1'b0, 8'd1);
        window(0, 2, 1, 3'd2, 2'd1, 1'b0, 8'd2);
        window(0, 2, 1, 3'd3, 2'd2, 1'b0, 8'd3);
        window(0, 2, 1, 3'd4, 2'd3, 1'b0, 8'd4);
        window(0, 2, 1, 3'd0, 2'd0, 1'b1, 8'd5);
        window(0, 2, 1, 3'd5, 2'd0, 1'b1, 8'd6);
        window(0, 2, 1, 3'd7, 2'd0, 1'b1, 8'd7);

        // Backpressure: result held while the latch moves underneath.
        reset_dut(0);
        drive(0, 1'b1, 3'd4, 1'b0);
        cyc(); cyc();
        en_a = 1'b0;
        cyc();                                  // E0
        cyc();                                  // capture
        for (int i = 0; i < 5; i++) begin
            lat_a = 3'(4 - ((i > 3) ? 3 : i));
            check("bp_valid", valid_a, 1);
            check("bp_data",  data_a,  2'd3);
            cyc();
        end
        check("bp_hold_cnt", cap_a, 8'd0);
        rdy_a = 1'b1;
        cyc();
        check("bp_xfer_valid", valid_a, 0);
        check("bp_xfer_cnt",   cap_a,   8'd1);
        cyc();
        check("bp_idle_ready_cnt", cap_a, 8'd1);

        // Overrun: one-cycle en pulse while a result waits.
        reset_dut(0);
        drive(0, 1'b1, 3'd2, 1'b0);
        cyc(); cyc();
        en_a = 1'b0;
        cyc(); cyc();
        check("ovr_pre_valid", valid_a, 1);
        check("ovr_pre_flag",  ovr_a,   0);
        en_a = 1'b1;
        cyc();
        en_a = 1'b0;
        lat_a = 3'd6;
        cyc();
        check("ovr_set",        ovr_a,   1);
        check("ovr_keep_valid", valid_a, 1);
        check("ovr_keep_data",  data_a,  2'd1);
        rdy_a = 1'b1;
        cyc();
        check("ovr_xfer_valid", valid_a, 0);
        check("ovr_sticky",     ovr_a,   1);
        check("ovr_xfer_cnt",   cap_a,   8'd1);
        cyc(); cyc();
        check("ovr_lost_window", valid_a, 0);

        // en held high across the transfer: that window is captured.
        drive(0, 1'b1, 3'd3, 1'b0);
        cyc(); cyc();
        en_a = 1'b0;
        cyc(); cyc();
        check("ovr2_valid", valid_a, 1);
        check("ovr2_data",  data_a,  2'd2);
        en_a = 1'b1;
        cyc();
        lat_a = 3'd4;
        rdy_a = 1'b1;
        cyc();
        check("ovr2_xfer_valid", valid_a, 0);
        check("ovr2_xfer_cnt",   cap_a,   8'd2);
        en_a = 1'b0;
        cyc();
        check("ovr2_e0_valid", valid_a, 0);
        cyc();
        check("ovr2_next_valid", valid_a, 1);
        check("ovr2_next_data",  data_a,  2'd3);
        check("ovr2_still_set",  ovr_a,   1);
        cyc();
        check("ovr2_next_cnt", cap_a, 8'd3);
        reset_dut(0);

        // Rise on the same edge as a transfer is not an overrun.
        drive(0, 1'b1, 3'd1, 1'b1);
        cyc(); cyc();
        en_a = 1'b0;
        cyc(); cyc();
        check("same_valid", valid_a, 1);
        check("same_data",  data_a,  2'd0);
        en_a = 1'b1;
        cyc();
        check("same_no_ovr", ovr_a,   0);
        check("same_valid0", valid_a, 0);
        en_a = 1'b0;
        lat_a = 3'd2;
        cyc();
        cyc();
        check("same_next_valid", valid_a, 1);
        check("same_next_data",  data_a,  2'd1);
        cyc();
        check("same_next_cnt", cap_a, 8'd2);
        check("same_ovr_end",  ovr_a, 0);

        // ---------------- Instance B: SETTLE_CYC=3, CNT_W=2 ----------------
        reset_dut(1);

        // Abort: en comes back 2 edges after E0.
        drive(1, 1'b1, 3'd2, 1'b1);
        cyc(); cyc();
        en_b = 1'b0;
        cyc();                                  // E0
        check("abort_e0", valid_b, 0);
        cyc();
        check("abort_e1", valid_b, 0);
        en_b = 1'b1;
        cyc();
        check("abort_e2", valid_b, 0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("abort_open", valid_b, 0);
        end
        check("abort_no_ovr", ovr_b, 0);
        check("abort_no_cnt", cap_b, 0);

        // Clean drop from OPEN, then counter saturation at 3.
        window(1, 0, 3, 3'd2, 2'd1, 1'b0, 8'd1);
        window(1, 1, 3, 3'd3, 2'd2, 1'b0, 8'd2);
        window(1, 1, 3, 3'd4, 2'd3, 1'b0, 8'd3);
        window(1, 1, 3, 3'd1, 2'd0, 1'b0, 8'd3);
        window(1, 1, 3, 3'd0, 2'd0, 1'b1, 8'd3);

        // Reset in the middle of SETTLE.
        drive(1, 1'b1, 3'd3, 1'b1);
        cyc(); cyc();
        en_b = 1'b0;
        cyc();                                  // E0
        cyc();
        rst_b = 1'b1;
        cyc();
        rst_b = 1'b0;
        check_all_zero(1, "midrst");
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("midrst_idle", valid_b, 0);
        end
        window(1, 2, 3, 3'd5, 2'd0, 1'b1, 8'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute bound in case stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
